// File: rtl/dff_pipeline.sv
// WIDTH-bit, DEPTH-stage enabled delay line with per-stage valid flags,
// synchronous clear and a registered count of valid stages.
module dff_pipeline #(
    parameter int unsigned     WIDTH       = 8,
    parameter int unsigned     DEPTH       = 2,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           en_i,
    input  logic                           clr_i,
    input  logic [WIDTH-1:0]               d_i,
    input  logic                           d_valid_i,
    output logic [WIDTH-1:0]               q_o,
    output logic                           q_valid_o,
    output logic [WIDTH*DEPTH-1:0]         taps_o,
    output logic [$clog2(DEPTH+1)-1:0]     valid_count_o,
    output logic                           primed_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
    logic [DEPTH-1:0]            vld_q, vld_d;
    logic [CntW-1:0]             cnt_q, cnt_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        cnt_d  = cnt_q;
        if (clr_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VALUE;
            end
            vld_d = '0;
            cnt_d = '0;
        end else if (en_i) begin
            data_d[0] = d_i;
            vld_d[0]  = d_valid_i;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                vld_d[i]  = vld_q[i-1];
            end
            // Entry and exit in the same cycle cancel; result always stays in 0..DEPTH.
            cnt_d = cnt_q + CntW'(d_valid_i) - CntW'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VALUE;
            end
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
            cnt_q  <= cnt_d;
        end
    end

    assign q_o           = data_q[DEPTH-1];
    assign q_valid_o     = vld_q[DEPTH-1];
    assign taps_o        = data_q;
    assign valid_count_o = cnt_q;
    assign primed_o      = (cnt_q == CntW'(DEPTH));

endmodule

// File: tb/tb_dff_pipeline.sv
// Bench for dff_pipeline: a WIDTH=8/DEPTH=3 build checked against a queue model
// and fixed vectors, plus a WIDTH=1/DEPTH=1 build checked against an enabled DFF.
module tb_dff_pipeline;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // Build A: WIDTH=8, DEPTH=3
    logic        a_en = 1'b0, a_clr = 1'b0, a_dv = 1'b0;
    logic [7:0]  a_d = 8'h00;
    logic [7:0]  a_q;
    logic        a_qv, a_primed;
    logic [23:0] a_taps;
    logic [1:0]  a_cnt;

    // Build B: WIDTH=1, DEPTH=1
    logic b_en = 1'b0, b_clr = 1'b0, b_dv = 1'b0, b_d = 1'b0;
    logic b_q, b_qv, b_taps, b_cnt, b_primed;

    dff_pipeline #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00)) u_a (
        .clk(clk), .rst_n(rst_n), .en_i(a_en), .clr_i(a_clr), .d_i(a_d),
        .d_valid_i(a_dv), .q_o(a_q), .q_valid_o(a_qv), .taps_o(a_taps),
        .valid_count_o(a_cnt), .primed_o(a_primed)
    );

    dff_pipeline #(.WIDTH(1), .DEPTH(1), .RESET_VALUE(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .en_i(b_en), .clr_i(b_clr), .d_i(b_d),
        .d_valid_i(b_dv), .q_o(b_q), .q_valid_o(b_qv), .taps_o(b_taps),
        .valid_count_o(b_cnt), .primed_o(b_primed)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference for A: stage i is element i of a queue; shifting is push_front/pop_back.
    logic [7:0] ma_d[$];
    bit         ma_v[$];
    bit         mb_d, mb_v;

    task automatic model_reset();
        ma_d = {};
        ma_v = {};
        for (int i = 0; i < 3; i++) begin
            ma_d.push_back(8'h00);
            ma_v.push_back(1'b0);
        end
        mb_d = 1'b0;
        mb_v = 1'b0;
    endtask

    task automatic model_edge();
        if (a_clr) begin
            for (int i = 0; i < 3; i++) begin
                ma_d[i] = 8'h00;
                ma_v[i] = 1'b0;
            end
        end else if (a_en) begin
            ma_d.push_front(a_d);
            ma_v.push_front(a_dv);
            void'(ma_d.pop_back());
            void'(ma_v.pop_back());
        end
        if (b_clr) begin
            mb_d = 1'b0;
            mb_v = 1'b0;
        end else if (b_en) begin
            mb_d = b_d;
            mb_v = b_dv;
        end
    endtask

    task automatic check_a_model(input string tag);
        logic [23:0] t;
        int          n;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            t[i*8 +: 8] = ma_d[i];
            n += int'(ma_v[i]);
        end
        chk({tag, ".q"}, 32'(a_q), 32'(ma_d[2]));
        chk({tag, ".q_valid"}, 32'(a_qv), 32'(ma_v[2]));
        chk({tag, ".taps"}, 32'(a_taps), 32'(t));
        chk({tag, ".count"}, 32'(a_cnt), 32'(n));
        chk({tag, ".primed"}, 32'(a_primed), 32'(n == 3));
    endtask

    task automatic check_b_model(input string tag);
        chk({tag, ".q"}, 32'(b_q), 32'(mb_d));
        chk({tag, ".q_valid"}, 32'(b_qv), 32'(mb_v));
        chk({tag, ".taps"}, 32'(b_taps), 32'(mb_d));
        chk({tag, ".count"}, 32'(b_cnt), 32'(mb_v));
        chk({tag, ".primed"}, 32'(b_primed), 32'(mb_v));
    endtask

    // One clock edge on both builds, then sample 1 time unit later.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_a_model({tag, ".A"});
        check_b_model({tag, ".B"});
    endtask

    task automatic drive_a(input logic en, input logic clr, input logic [7:0] d, input logic dv);
        a_en  = en;
        a_clr = clr;
        a_d   = d;
        a_dv  = dv;
    endtask

    typedef struct {
        logic       en;
        logic       clr;
        logic [7:0] d;
        logic       dv;
        logic [7:0] exp_q;
        logic       exp_qv;
        logic [1:0] exp_cnt;
        logic       exp_primed;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 2'd1, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 2'd2, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h11, 1'b1, 2'd3, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 8'h44, 1'b1, 8'h22, 1'b1, 2'd3, 1'b1};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b1, 2'd2, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 1'b1, 2'd1, 1'b0};
        vecs[6] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0};

        // Asynchronous reset with no clock edge yet.
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset.q", 32'(a_q), 32'h00);
        chk("reset.q_valid", 32'(a_qv), 32'h0);
        chk("reset.taps", 32'(a_taps), 32'h0);
        chk("reset.count", 32'(a_cnt), 32'h0);
        chk("reset.primed", 32'(a_primed), 32'h0);
        check_b_model("reset.B");
        @(negedge clk);
        rst_n = 1'b1;

        // Latency and order.
        foreach (vecs[i]) begin
            drive_a(vecs[i].en, vecs[i].clr, vecs[i].d, vecs[i].dv);
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.q_tbl", i), 32'(a_q), 32'(vecs[i].exp_q));
            chk($sformatf("vec%0d.qv_tbl", i), 32'(a_qv), 32'(vecs[i].exp_qv));
            chk($sformatf("vec%0d.cnt_tbl", i), 32'(a_cnt), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d.primed_tbl", i), 32'(a_primed), 32'(vecs[i].exp_primed));
        end

        // Stall: two entries in, then five disabled edges with junk on d.
        drive_a(1'b1, 1'b0, 8'hA1, 1'b1);
        step("fill1");
        drive_a(1'b1, 1'b0, 8'hA2, 1'b1);
        step("fill2");
        for (int i = 0; i < 5; i++) begin
            drive_a(1'b0, 1'b0, 8'hFF, 1'b1);
            step($sformatf("stall%0d", i));
            chk($sformatf("stall%0d.taps_fix", i), 32'(a_taps), 32'h0000_A1A2);
            chk($sformatf("stall%0d.cnt_fix", i), 32'(a_cnt), 32'd2);
        end
        drive_a(1'b1, 1'b0, 8'h00, 1'b0);
        step("resume");
        chk("resume.q_fix", 32'(a_q), 32'hA1);
        chk("resume.qv_fix", 32'(a_qv), 32'h1);

        // Bubble: valid pattern 1,0,1 from a cleared pipe.
        drive_a(1'b0, 1'b1, 8'h00, 1'b0);
        step("bub_clr");
        drive_a(1'b1, 1'b0, 8'h05, 1'b1);
        step("bub1");
        drive_a(1'b1, 1'b0, 8'h06, 1'b0);
        step("bub2");
        drive_a(1'b1, 1'b0, 8'h07, 1'b1);
        step("bub3");
        chk("bub3.q_fix", 32'(a_q), 32'h05);
        chk("bub3.qv_fix", 32'(a_qv), 32'h1);
        chk("bub3.cnt_fix", 32'(a_cnt), 32'd2);
        drive_a(1'b1, 1'b0, 8'h00, 1'b0);
        step("bub4");
        chk("bub4.q_fix", 32'(a_q), 32'h06);
        chk("bub4.qv_fix", 32'(a_qv), 32'h0);
        step("bub5");
        chk("bub5.q_fix", 32'(a_q), 32'h07);
        chk("bub5.qv_fix", 32'(a_qv), 32'h1);

        // Clear beats enable on a full pipe.
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b0, 8'(8'h50 + i), 1'b1);
            step($sformatf("full%0d", i));
        end
        chk("full.primed_fix", 32'(a_primed), 32'h1);
        drive_a(1'b1, 1'b1, 8'h99, 1'b1);
        step("clr");
        chk("clr.taps_fix", 32'(a_taps), 32'h0);
        chk("clr.cnt_fix", 32'(a_cnt), 32'h0);
        chk("clr.primed_fix", 32'(a_primed), 32'h0);

        // Async reset mid-stream, no clock edge involved.
        drive_a(1'b1, 1'b0, 8'h3C, 1'b1);
        step("pre_rst1");
        step("pre_rst2");
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst.taps_fix", 32'(a_taps), 32'h0);
        chk("arst.cnt_fix", 32'(a_cnt), 32'h0);
        chk("arst.qv_fix", 32'(a_qv), 32'h0);
        check_a_model("arst");
        #1 rst_n = 1'b1;

        // Random traffic on A.
        for (int i = 0; i < 400; i++) begin
            drive_a(($urandom_range(9, 0) < 7), ($urandom_range(19, 0) == 0),
                    8'($urandom), 1'($urandom));
            step("randA");
        end
        drive_a(1'b0, 1'b0, 8'h00, 1'b0);

        // Random traffic on the 1x1 build.
        for (int i = 0; i < 1000; i++) begin
            b_en  = 1'($urandom);
            b_clr = ($urandom_range(19, 0) == 0);
            b_d   = 1'($urandom);
            b_dv  = 1'($urandom);
            step("randB");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dff_pipeline.md
Name: dff_pipeline

Overview:
Parametrised successor to the single-bit D flip-flop primitive. It is a WIDTH-bit, DEPTH-stage register pipeline (delay line). Per-stage valid tracking, clock enable, synchronous clear and a registered occupancy counter are built in. It sits in the toolbox alongside the other primitives and serves as the standard retiming/delay element for I2C BERT datapaths, e.g. aligning data with delayed strobes or compare paths.

Parameters:
WIDTH, 8, data bits per stage (>=1)
DEPTH, 2, number of register stages (>=1); DEPTH=1 degenerates to an enabled DFF with valid
RESET_VALUE, {WIDTH{1'b0}}, value loaded into every data stage on reset or clear

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
en  input  1  advance enable; 1 = shift one stage this cycle, 0 = hold all state
clr  input  1  synchronous clear; priority over en
d  input  WIDTH  data into stage 0
d_valid  input  1  valid flag accompanying d
q  output  WIDTH  data from stage DEPTH-1
q_valid  output  1  valid flag of stage DEPTH-1
taps  output  WIDTH*DEPTH  all stage data, stage i at bits [i*WIDTH +: WIDTH]
valid_count  output  $clog2(DEPTH+1)  number of stages currently holding valid data (registered)
primed  output  1  1 when valid_count == DEPTH

Behaviour:
- State: data[0..DEPTH-1] (WIDTH each), vld[0..DEPTH-1], cnt.
- Reset (rst_n=0, async, no clock needed): data[i]=RESET_VALUE, vld[i]=0, cnt=0. Outputs are therefore q=RESET_VALUE, q_valid=0, taps all RESET_VALUE, valid_count=0, primed=0. Release is synchronous to the next clk edge; the first posedge with rst_n=1 may already shift.
- Per posedge, priority clr > en > hold:
  - clr=1: data[i]=RESET_VALUE, vld[i]=0, cnt=0, regardless of en/d/d_valid.
  - en=1: data[0]<=d, vld[0]<=d_valid; data[i]<=data[i-1], vld[i]<=vld[i-1] for i>=1. cnt<=cnt + d_valid - vld[DEPTH-1], evaluated with pre-edge values. Simultaneous entry and exit leaves cnt unchanged.
  - en=0: all state holds. d and d_valid are ignored.
- Data shifts whether or not d_valid=1. Valid only annotates; invalid entries still carry d into the pipe.
- Latency: with en held at 1, a value presented at edge N appears on q after edge N+DEPTH-1. That is DEPTH registered edges, counting the capture edge. Stalled cycles (en=0) add one cycle each.
- Outputs q, q_valid, taps, valid_count and primed derive from registers only. There is no combinational path from any input to any output.
- cnt range is 0..DEPTH. Overflow and underflow are impossible by construction. Invariant: cnt == popcount(vld) at all times.
- primed = (cnt == DEPTH). It is a combinational compare of the registered cnt.
- Reset mid-operation discards all in-flight data immediately. clr does the same on the next edge.
- DEPTH=1: taps==q; cnt is 1 bit; primed==q_valid.

Test Plan:
- Reset: WIDTH=8, DEPTH=3. Drive rst_n=0 with no clock -> q=0x00, q_valid=0, valid_count=0, primed=0 immediately.
- Latency/order: en=1, d_valid=1, d=0x11,0x22,0x33,0x44 on consecutive edges -> q=0x11 (q_valid=1) after edge 3, then 0x22, 0x33, 0x44. valid_count goes 1,2,3,3 and primed=1 from edge 3.
- Stall: fill 0xA1,0xA2, then en=0 for 5 edges with d=0xFF -> taps unchanged, q held, valid_count=2. Resume en=1 -> 0xA1 exits 5 cycles later than it would without the stall.
- Bubble: d_valid pattern 1,0,1 with d=0x05,0x06,0x07 -> q shows 0x05(v=1), 0x06(v=0), 0x07(v=1). valid_count peaks at 2 and never exceeds popcount(vld).
- Clear priority: pipeline full (primed=1), assert clr=1 and en=1 with d=0x99, d_valid=1 -> after that edge all taps=RESET_VALUE, valid_count=0, and 0x99 is not captured. Async rst_n pulse mid-stream gives the same result without a clock edge.
- DEPTH=1, WIDTH=1 build: random d/en for 1000 cycles -> q matches a reference enabled DFF each cycle; invariant cnt==popcount(vld) checked every cycle for all configurations.
